serial_chunk_adder: RTL and testbench

SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

---
 rtl/serial_chunk_adder_pkg.sv | 20 ++
 rtl/serial_chunk_adder_if.sv | 44 ++++
 rtl/serial_chunk_adder_chunk_adder.sv | 30 +++
 rtl/serial_chunk_adder.sv | 137 +++++++++++++
 tb/tb_serial_chunk_adder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_chunk_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_chunk_adder_pkg
// Shared declarations for the serial chunk adder:
//   state_t    - controller states (IDLE / BUSY / DONE)
//   cnt_width  - width of the chunk counter for N chunks (never below 1 bit)
// ---------------------------------------------------------------------------
package serial_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_chunk_adder_if.sv
// ---------------------------------------------------------------------------
// serial_chunk_adder_if
// Operand / result handshake bundle for serial_chunk_adder.
//   in_valid, in_ready   - operand handshake (producer -> adder)
//   a, b, carry_in       - operands and initial carry
//   sub                  - subtract select (only with SERIAL_CHUNK_ADDER_SUB_EN)
//   out_valid, out_ready - result handshake (adder -> consumer)
//   sum, carry_out       - registered result
// Modports: master = the side that drives operands and consumes results,
//           slave  = the adder itself.
// WIDTH must match the WIDTH of the attached adder.
// ---------------------------------------------------------------------------
interface serial_chunk_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );

  modport slave (
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out
  );
endinterface

// File: rtl/serial_chunk_adder_chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder
// Purely combinational CHUNK-bit ripple-carry adder.
//   x, y  - CHUNK-bit addends
//   cin   - carry into bit 0
//   s     - CHUNK-bit sum
//   cout  - carry out of the top bit
// ---------------------------------------------------------------------------
module chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    assign s[gi]     = x[gi] ^ y[gi] ^ w_c[gi];
    assign w_c[gi+1] = (x[gi] & y[gi]) | (x[gi] & w_c[gi]) | (y[gi] & w_c[gi]);
  end

  assign cout = w_c[CHUNK];
endmodule

// File: rtl/serial_chunk_adder.sv
// ---------------------------------------------------------------------------
// serial_chunk_adder
// Adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, using a
// single chunk_adder reused every BUSY cycle. Result appears N = WIDTH/CHUNK
// edges after the operands are accepted and is held until consumed.
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-high reset (discards any operation in flight)
//   bus  - serial_chunk_adder_if slave modport (operand/result handshakes)
// Optional feature: define SERIAL_CHUNK_ADDER_SUB_EN to add the bus.sub input;
// sub = 1 computes a - b as a + ~b + 1 (carry_out is NOT borrow, carry_in is
// ignored). Without the macro the block is add-only.
// ---------------------------------------------------------------------------
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_chunk_adder_if.slave  bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("serial_chunk_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  state_t           r_state;
  state_t           w_state_next;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;
  int               w_base;
  logic [CHUNK-1:0] w_x;
  logic [CHUNK-1:0] w_y;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  logic             r_sub;
`endif

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == LAST);

  // ---------------- controller ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_next = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_carry_out;

  // ---------------- datapath ----------------
  assign w_base = int'(r_cnt) * CHUNK;
  assign w_x    = r_a[w_base +: CHUNK];
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  // Subtraction adds the inverted subtrahend; the +1 enters as the initial carry.
  assign w_y    = r_sub ? ~r_b[w_base +: CHUNK] : r_b[w_base +: CHUNK];
`else
  assign w_y    = r_b[w_base +: CHUNK];
`endif

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .x    (w_x),
    .y    (w_y),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      r_sub       <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_cnt <= '0;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      r_sub   <= bus.sub;
      r_carry <= bus.sub ? 1'b1 : bus.carry_in;
`else
      r_carry <= bus.carry_in;
`endif
    end else if (r_state == BUSY) begin
      r_sum[w_base +: CHUNK] <= w_s;
      r_carry                <= w_cout;
      if (w_last) begin
        r_cnt       <= '0;
        r_carry_out <= w_cout;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_chunk_adder.sv
module tb_serial_chunk_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_chunk_adder_if #(.WIDTH(32)) bus32();
  serial_chunk_adder_if #(.WIDTH(8))  bus8();

  serial_chunk_adder #(.WIDTH(32), .CHUNK(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  serial_chunk_adder #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        hold;
    int          stall;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, one extra bit for the carry.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

  // One operation on the 32-bit instance. hold keeps in_valid high with
  // scrambled operands through BUSY; stall keeps out_ready low in DONE.
  task automatic do_op32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input logic hold, input int stall,
                         output logic [31:0] s, output logic c, output int lat);
    @(negedge clk);
    check("in_ready_idle", 32'(bus32.in_ready), 32'd1);
    bus32.in_valid = 1'b1;
    bus32.a = a;
    bus32.b = b;
    bus32.carry_in = cin;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    bus32.sub = sub;
`endif
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      bus32.a = ~a;
      bus32.b = a ^ b ^ 32'h5A5A_A5A5;
      bus32.carry_in = ~cin;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      bus32.sub = ~sub;
`endif
    end else begin
      bus32.in_valid = 1'b0;
    end
    check("in_ready_busy", 32'(bus32.in_ready), 32'd0);
    lat = 0;
    while (!bus32.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus32.in_valid = 1'b0;
    check("out_valid_seen", 32'(bus32.out_valid), 32'd1);
    s = bus32.sum;
    c = bus32.carry_out;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_sum", bus32.sum, s);
      check("stall_cout", 32'(bus32.carry_out), 32'(c));
      check("stall_out_valid", 32'(bus32.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus32.in_ready), 32'd0);
    end
    bus32.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus32.out_ready = 1'b0;
    check("post_out_valid", 32'(bus32.out_valid), 32'd0);
    check("post_in_ready", 32'(bus32.in_ready), 32'd1);
    $display("[TB] op32 a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b lat=%0d", a, b, cin, sub, s, c, lat);
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] exp_s, input logic exp_c);
    @(negedge clk);
    check("w8_in_ready", 32'(bus8.in_ready), 32'd1);
    bus8.in_valid = 1'b1;
    bus8.a = a;
    bus8.b = b;
    bus8.carry_in = cin;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    check("w8_not_valid_at_t", 32'(bus8.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("w8_valid_at_t1", 32'(bus8.out_valid), 32'd1);
    check("w8_sum", 32'(bus8.sum), 32'(exp_s));
    check("w8_cout", 32'(bus8.carry_out), 32'(exp_c));
    $display("[TB] op8 a=%h b=%h cin=%b -> sum=%h cout=%b", a, b, cin, bus8.sum, bus8.carry_out);
    bus8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("w8_back_idle", 32'(bus8.in_ready), 32'd1);
  endtask

  vec_t        vecs [7];
  logic [31:0] s;
  logic        c;
  int          lat;
  logic [32:0] ref_v;
  logic        sub_r;
  logic        seen_valid;

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 0, 32'h2345_678A, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 0, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 5, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 2, 32'h0000_0010, 1'b0};
    vecs[6] = '{32'h89AB_CDEF, 32'h7654_3210, 1'b0, 1'b1, 0, 32'hFFFF_FFFF, 1'b0};

    rst = 1'b1;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.carry_in = 1'b0; bus32.out_ready = 1'b0;
    bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.carry_in  = 1'b0; bus8.out_ready  = 1'b0;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    bus32.sub = 1'b0;
    bus8.sub  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(bus32.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus32.out_valid), 32'd0);
    check("reset_sum", bus32.sum, 32'd0);
    check("reset_cout", 32'(bus32.carry_out), 32'd0);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      do_op32(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].hold, vecs[i].stall, s, c, lat);
      check($sformatf("vec%0d_sum", i), s, vecs[i].exp_sum);
      check($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_latency", i), lat, 32'd8);
    end

    // Reset in the middle of BUSY with counter = 3
    @(negedge clk);
    bus32.in_valid = 1'b1; bus32.a = 32'hDEAD_BEEF; bus32.b = 32'h0000_0001; bus32.carry_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus32.out_valid), 32'd0);
    check("midrst_sum", bus32.sum, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus32.in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus32.out_valid) seen_valid = 1'b1;
    end
    check("midrst_no_result", 32'(seen_valid), 32'd0);
    do_op32(32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 0, s, c, lat);
    check("after_rst_sum", s, 32'd5);
    check("after_rst_cout", 32'(c), 32'd0);

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    do_op32(32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 0, s, c, lat);
    check("sub_5m7_sum", s, 32'hFFFF_FFFE);
    check("sub_5m7_cout", 32'(c), 32'd0);
    do_op32(32'd7, 32'd5, 1'b0, 1'b1, 1'b0, 0, s, c, lat);
    check("sub_7m5_sum", s, 32'd2);
    check("sub_7m5_cout", 32'(c), 32'd1);
`endif

    // Randomized against the whole-word model
    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      logic        rc;
      ra = $urandom;
      rb = (i % 4 == 0) ? ~ra : 32'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      sub_r = 1'($urandom_range(0, 1));
`else
      sub_r = 1'b0;
`endif
      ref_v = model(ra, rb, rc, sub_r);
      do_op32(ra, rb, rc, sub_r, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), s, c, lat);
      check($sformatf("rnd%0d_sum", i), s, ref_v[31:0]);
      check($sformatf("rnd%0d_cout", i), 32'(c), 32'(ref_v[32]));
      check($sformatf("rnd%0d_latency", i), lat, 32'd8);
    end

    // Single-chunk instance (CHUNK == WIDTH)
    do_op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    do_op8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    do_op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
